fp_operand_issuer: RTL and testbench
====================================

# fp_operand_issuer

Front end of the 5-stage floating-point add/subtract pipeline. Accepts IEEE-754 single-precision operand pairs over a valid/ready handshake and buffers them in a small FIFO. Unpacks each pair into the pipeline's packed mantissa/exponent/op format and drives the pipeline's shared `load`. A valid/tag/class token runs alongside the pipeline so the back end knows which result word is real, which request it belongs to, and whether it needs a special-value override.

## Interface
- `PIPE_DEPTH`, 5: load-enabled register stages inside the add/sub pipeline.
- `FIFO_DEPTH`, 2: operand buffer entries, minimum 1.
- `TAG_W`, 4: request tag width.

- `clk` input 1: single clock, rising edge.
- `clear` input 1: asynchronous, active-low reset. All state is cleared while low.
- `hold` input 1: downstream stall. Freezes the pipeline and this block's issue side.
- `in_valid` input 1: operand pair offered.
- `in_ready` output 1: `!fifo_full`. Registered-state only, with no combinational path from `hold`.
- `in_a`, `in_b` input 32: IEEE-754 operands.
- `in_op` input 1: 0 = add, 1 = subtract.
- `in_tag` input `TAG_W`: returned with the result.
- `mantise` output 48: `{sA, fracA[22:0], sB, fracB[22:0]}`, registered.
- `exponent` output 16: `{expA[7:0], expB[7:0]}`, registered.
- `op` output 1: registered op.
- `load` output 1: `!hold`, shared load for every pipeline register.
- `res_valid` output 1: pipeline result word corresponds to a real issue.
- `res_tag` output `TAG_W`: tag of that issue.
- `res_class` output 2: 00 normal, 01 zero/denormal operand, 10 infinity, 11 NaN.

## Operation
- **Push:** when `in_valid && in_ready`, the entry `{a, b, op, tag}` is written at the FIFO tail.
- **Issue:** on each edge with `load=1`:
  - If the FIFO is non-empty, the head is popped, unpacked and registered into `mantise`/`exponent`/`op`, and `trk_v[0]` is set to 1 with the tag and class captured.
  - If the FIFO is empty, `mantise`/`exponent`/`op` are loaded with zeros and `trk_v[0]` is set to 0 (bubble).
- **Hold:** on each edge with `load=0`, the output registers and all tracking stages keep their values. Push is still allowed if the FIFO is not full.
- **Tracking:** `trk_v`, `trk_tag` and `trk_cls` each have `PIPE_DEPTH+1` stages and shift by one on each `load=1` edge. `res_valid = trk_v[PIPE_DEPTH]`; `res_tag` and `res_class` come from the same stage.
- **Classification** happens at unpack time from both operands, with precedence NaN > infinity > zero:
  - NaN: exponent 255 with fraction ≠ 0.
  - Infinity: exponent 255 with fraction 0.
  - Zero/denormal: exponent 0.
- **Bypass:** there is no write-to-issue bypass. An entry pushed at edge N is issued at the first `load=1` edge strictly after N.
- **Full FIFO:** `in_ready=0`, so a pop and a push cannot both happen at a full FIFO. A push and a pop in the same edge at partial fill is legal and leaves the count unchanged.
- **Pointers:** wrap modulo `FIFO_DEPTH`. The count is held in `$clog2(FIFO_DEPTH+1)` bits.

## Timing
- **Reset (`clear=0`), applies immediately:**
  - FIFO empty, `in_ready=1`.
  - `mantise=0`, `exponent=0`, `op=0`.
  - All `trk_*` = 0, so `res_valid=0`, `res_tag=0`, `res_class=00`.
  - `load` follows `hold` combinationally.
- **Latency** with `hold=0` throughout: accept at edge N, operands on `mantise` after N+1, `res_valid` high after edge N+1+`PIPE_DEPTH` (N+6 at default). `res_valid` stays high for exactly one cycle per issue.
- **Throughput:** one pair per cycle sustained when `in_valid` stays high and `hold=0`.
- **Reset mid-operation:** all in-flight tokens are lost and no `res_valid` is produced for them. The first accept after `clear` rises behaves as from cold.

## Structure
- Package `fp_issue_pkg` holds:
  - Class codes `CLS_NORMAL`/`CLS_ZERO`/`CLS_INF`/`CLS_NAN`.
  - Field constants `EXP_W=8`, `FRAC_W=23`, `EXP_MAX=8'hFF`.
  - The packed FIFO entry typedef.
- Sub-module `fp_operand_fifo` holds the storage, pointers and count, with push/pop/full/empty. The top level holds the unpack, classify and tracking shift registers.

## Test plan
- **Single op:** reset, then push a=0x3F800000, b=0x40000000, op=0, tag=3 at edge 0. Required: `mantise=48'h0`, `exponent=16'h7F80` after edge 1; `res_valid=1`, `res_tag=3`, `res_class=00` after edge 6 only.
- **Back-to-back:** tags 1..8 pushed on consecutive edges with `hold=0`. Required: `in_ready` never drops; `res_valid` high on 8 consecutive cycles with tags 1..8 in order.
- **Full/hold:** `hold=1`, push tags 5 and 6. Required: `in_ready=0` after the second push; a third `in_valid` is not accepted. After `hold` is released, tags 5 and 6 return in order and the FIFO refills.
- **Special classes:**
  - a=0x7FC00000 with b=0x7F800000 → `res_class=11`.
  - a=0xFF800000 with b=0x00000000 → `10`.
  - a=0x00000001 with b=0x3F800000 → `01`.
- **Bubbles and hold mid-flight:** push one op, assert `hold` for 3 cycles after edge 3. Required: `res_valid` appears exactly 3 cycles later than in the single-op case, and the bubbles ahead of it never raise `res_valid`.
- **Reset mid-flight:** push 3 ops, pull `clear` low for 1 cycle at edge 2. Required: `res_valid` stays 0 thereafter, and `in_ready=1` and all outputs are zero during reset.

Source files
------------

// File: rtl/fp_issue_pkg.sv
// Shared types and constants for the FP operand issuer: class codes,
// IEEE-754 single-precision field widths, FIFO entry payload and classifier.
package fp_issue_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned WORD_W = 1 + EXP_W + FRAC_W;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    CLS_NORMAL = 2'b00,
    CLS_ZERO   = 2'b01,
    CLS_INF    = 2'b10,
    CLS_NAN    = 2'b11
  } cls_e;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              op;
  } fp_entry_t;

  // Operand-pair class, precedence NaN > infinity > zero/denormal; sign bits are not needed.
  function automatic cls_e classify(input logic [WORD_W-2:0] a, input logic [WORD_W-2:0] b);
    logic [EXP_W-1:0]  ea;
    logic [EXP_W-1:0]  eb;
    logic [FRAC_W-1:0] fa;
    logic [FRAC_W-1:0] fb;
    ea = a[FRAC_W +: EXP_W];
    eb = b[FRAC_W +: EXP_W];
    fa = a[FRAC_W-1:0];
    fb = b[FRAC_W-1:0];
    if ((ea == EXP_MAX && fa != '0) || (eb == EXP_MAX && fb != '0)) begin
      return CLS_NAN;
    end
    if (ea == EXP_MAX || eb == EXP_MAX) begin
      return CLS_INF;
    end
    if (ea == '0 || eb == '0) begin
      return CLS_ZERO;
    end
    return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/fp_operand_issuer_if.sv
// Operand-pair request channel: valid/ready handshake plus the two operands, op and tag.
interface fp_operand_issuer_if #(
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic             in_op;
  logic [TAG_W-1:0] in_tag;

  modport master (output in_valid, output in_a, output in_b, output in_op, output in_tag,
                  input in_ready);
  modport slave  (input in_valid, input in_a, input in_b, input in_op, input in_tag,
                  output in_ready);
endinterface

// File: rtl/fp_operand_fifo.sv
// Small circular operand buffer; full/empty decode from the registered count only.
module fp_operand_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 69
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/fp_operand_issuer.sv
// Front end of the FP add/sub pipeline: buffers operand pairs, unpacks and issues
// them under the shared load, and tracks valid/tag/class alongside the pipeline.
module fp_operand_issuer
  import fp_issue_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 5,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 hold,
  fp_operand_issuer_if.slave   req,
  output logic [47:0]          mantise,
  output logic [15:0]          exponent,
  output logic                 op,
  output logic                 load,
  output logic                 res_valid,
  output logic [TAG_W-1:0]     res_tag,
  output logic [1:0]           res_class
);

  localparam int unsigned ENTRY_W = $bits(fp_entry_t) + TAG_W;

  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;
  fp_entry_t          head;
  logic [TAG_W-1:0]   head_tag;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  logic [47:0]        mantise_q, mantise_d;
  logic [15:0]        exponent_q, exponent_d;
  logic               op_q, op_d;
  logic [TAG_W-1:0]   tag_d;
  cls_e               cls_d;

  logic [PIPE_DEPTH:0] trk_v_q;
  logic [TAG_W-1:0]    trk_tag_q [PIPE_DEPTH+1];
  cls_e                trk_cls_q [PIPE_DEPTH+1];

  assign load         = !hold;
  assign req.in_ready = !full;
  assign push         = req.in_valid && !full;
  assign pop          = load && !empty;
  assign wr_data      = {req.in_a, req.in_b, req.in_op, req.in_tag};
  assign {head, head_tag} = rd_data;

  fp_operand_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .clear     (clear),
    .push_i    (push),
    .wr_data_i (wr_data),
    .pop_i     (pop),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Unpack the head entry; an empty FIFO issues an all-zero bubble.
  always_comb begin
    mantise_d  = '0;
    exponent_d = '0;
    op_d       = 1'b0;
    tag_d      = '0;
    cls_d      = CLS_NORMAL;
    if (!empty) begin
      mantise_d  = {head.a[WORD_W-1], head.a[FRAC_W-1:0], head.b[WORD_W-1], head.b[FRAC_W-1:0]};
      exponent_d = {head.a[FRAC_W +: EXP_W], head.b[FRAC_W +: EXP_W]};
      op_d       = head.op;
      tag_d      = head_tag;
      cls_d      = classify(head.a[WORD_W-2:0], head.b[WORD_W-2:0]);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      mantise_q  <= '0;
      exponent_q <= '0;
      op_q       <= 1'b0;
      trk_v_q    <= '0;
      for (int i = 0; i <= int'(PIPE_DEPTH); i++) begin
        trk_tag_q[i] <= '0;
        trk_cls_q[i] <= CLS_NORMAL;
      end
    end else if (load) begin
      mantise_q    <= mantise_d;
      exponent_q   <= exponent_d;
      op_q         <= op_d;
      trk_v_q      <= {trk_v_q[PIPE_DEPTH-1:0], !empty};
      trk_tag_q[0] <= tag_d;
      trk_cls_q[0] <= cls_d;
      for (int i = 1; i <= int'(PIPE_DEPTH); i++) begin
        trk_tag_q[i] <= trk_tag_q[i-1];
        trk_cls_q[i] <= trk_cls_q[i-1];
      end
    end
  end

  assign mantise   = mantise_q;
  assign exponent  = exponent_q;
  assign op        = op_q;
  assign res_valid = trk_v_q[PIPE_DEPTH];
  assign res_tag   = trk_tag_q[PIPE_DEPTH];
  assign res_class = 2'(trk_cls_q[PIPE_DEPTH]);

endmodule

// File: tb/tb_fp_operand_issuer.sv
// Directed bench for fp_operand_issuer: latency, throughput, full/hold, classes, reset.
module tb_fp_operand_issuer;

  logic        clk;
  logic        clear;
  logic        hold;
  logic [47:0] mantise;
  logic [15:0] exponent;
  logic        op;
  logic        load;
  logic        res_valid;
  logic [3:0]  res_tag;
  logic [1:0]  res_class;

  int vectors = 0;
  int errs    = 0;

  fp_operand_issuer_if #(.TAG_W(4)) bus ();

  fp_operand_issuer #(.PIPE_DEPTH(5), .FIFO_DEPTH(2), .TAG_W(4)) dut (
    .clk       (clk),
    .clear     (clear),
    .hold      (hold),
    .req       (bus),
    .mantise   (mantise),
    .exponent  (exponent),
    .op        (op),
    .load      (load),
    .res_valid (res_valid),
    .res_tag   (res_tag),
    .res_class (res_class)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic o, input logic [3:0] t);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_op    = o;
    bus.in_tag   = t;
  endtask

  initial begin
    clear = 1'b0;
    hold  = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);

    // Reset state
    #12;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_mantise", 64'(mantise), 64'd0);
    chk("rst_exponent", 64'(exponent), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_load_hold0", 64'(load), 64'd1);
    hold = 1'b1;
    #1;
    chk("rst_load_hold1", 64'(load), 64'd0);
    hold = 1'b0;
    step();
    clear = 1'b1;

    // Single op: push at edge 0, result after edge 6 only
    drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 4'd3);
    for (int c = 0; c <= 8; c++) begin
      step();
      if (c == 0) drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      if (c == 1) begin
        chk("single_mantise", 64'(mantise), 64'h0);
        chk("single_exponent", 64'(exponent), 64'h7F80);
      end
      chk($sformatf("single_valid_e%0d", c), 64'(res_valid), 64'(c == 6));
      if (c == 6) begin
        chk("single_tag", 64'(res_tag), 64'd3);
        chk("single_class", 64'(res_class), 64'd0);
      end
    end

    // Back-to-back: tags 1..8 on consecutive edges
    for (int c = 0; c <= 15; c++) begin
      if (c < 8) begin
        drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 4'(c + 1));
        chk($sformatf("b2b_ready_%0d", c), 64'(bus.in_ready), 64'd1);
      end else begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      end
      step();
      chk($sformatf("b2b_valid_e%0d", c), 64'(res_valid), 64'(c >= 6 && c <= 13));
      if (c >= 6 && c <= 13) chk($sformatf("b2b_tag_e%0d", c), 64'(res_tag), 64'(c - 5));
    end

    // Full/hold: fill under hold, third offer refused, then drain in order and refill
    hold = 1'b1;
    drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 4'd5);
    step();
    chk("full_ready_after1", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 4'd6);
    step();
    chk("full_ready_after2", 64'(bus.in_ready), 64'd0);
    chk("full_load", 64'(load), 64'd0);
    drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b1, 4'd7);
    step();
    chk("full_ready_after3", 64'(bus.in_ready), 64'd0);
    chk("full_no_valid", 64'(res_valid), 64'd0);
    hold = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      step();
      if (c == 0) chk("full_ready_release", 64'(bus.in_ready), 64'd1);
      if (c == 1) drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      if (c == 2) chk("refill_op", 64'(op), 64'd1);
      chk($sformatf("full_valid_e%0d", c), 64'(res_valid), 64'(c >= 5 && c <= 7));
      if (c >= 5 && c <= 7) chk($sformatf("full_tag_e%0d", c), 64'(res_tag), 64'(c));
    end

    // Special classes: NaN > inf, inf > zero, denormal
    for (int c = 0; c <= 9; c++) begin
      case (c)
        0: drive(1'b1, 32'h7FC00000, 32'h7F800000, 1'b0, 4'd9);
        1: drive(1'b1, 32'hFF800000, 32'h00000000, 1'b1, 4'd10);
        2: drive(1'b1, 32'h00000001, 32'h3F800000, 1'b0, 4'd11);
        default: drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      endcase
      step();
      case (c)
        1: begin
          chk("nan_mantise", 64'(mantise), 64'h400000000000);
          chk("nan_exponent", 64'(exponent), 64'hFFFF);
        end
        2: begin
          chk("inf_mantise", 64'(mantise), 64'h800000000000);
          chk("inf_exponent", 64'(exponent), 64'hFF00);
          chk("inf_op", 64'(op), 64'd1);
        end
        3: begin
          chk("den_mantise", 64'(mantise), 64'h000001000000);
          chk("den_exponent", 64'(exponent), 64'h007F);
        end
        6: begin
          chk("cls_nan", 64'(res_class), 64'd3);
          chk("cls_nan_tag", 64'(res_tag), 64'd9);
        end
        7: chk("cls_inf", 64'(res_class), 64'd2);
        8: chk("cls_zero", 64'(res_class), 64'd1);
        default: ;
      endcase
      chk($sformatf("cls_valid_e%0d", c), 64'(res_valid), 64'(c >= 6 && c <= 8));
    end

    // Hold mid-flight: edges 4..6 frozen, result delayed from edge 6 to edge 9
    drive(1'b1, 32'h40400000, 32'h3F800000, 1'b1, 4'd12);
    for (int c = 0; c <= 11; c++) begin
      hold = (c >= 4 && c <= 6);
      step();
      if (c == 0) drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      chk($sformatf("hold_valid_e%0d", c), 64'(res_valid), 64'(c == 9));
      if (c == 9) chk("hold_tag", 64'(res_tag), 64'd12);
    end
    hold = 1'b0;

    // Reset mid-flight: tokens lost, outputs zero during reset
    drive(1'b1, 32'h3F800000, 32'h40000000, 1'b1, 4'd13);
    step();
    drive(1'b1, 32'hBF800000, 32'h40000000, 1'b1, 4'd14);
    step();
    drive(1'b1, 32'h40000000, 32'h40400000, 1'b1, 4'd15);
    step();
    clear = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
    #1;
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_mantise", 64'(mantise), 64'd0);
    chk("mid_rst_exponent", 64'(exponent), 64'd0);
    chk("mid_rst_op", 64'(op), 64'd0);
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_tag", 64'(res_tag), 64'd0);
    chk("mid_rst_class", 64'(res_class), 64'd0);
    step();
    clear = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("post_rst_valid_%0d", c), 64'(res_valid), 64'd0);
    end

    // First accept after reset behaves as from cold
    drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 4'd2);
    for (int c = 0; c <= 7; c++) begin
      step();
      if (c == 0) drive(1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
      chk($sformatf("cold_valid_e%0d", c), 64'(res_valid), 64'(c == 6));
      if (c == 6) chk("cold_tag", 64'(res_tag), 64'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
